// File: rtl/proc_loader_pkg.sv
// Shared types and constants for the processor memory loader.
package proc_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PACK,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs an 8-bit valid/ready stream into little-endian 32-bit words.
module loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        in_val_i,
    input  logic [7:0]  in_data_i,
    output logic        in_rdy_o,
    output logic        word_val_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        take;

    assign in_rdy_o   = en_i;
    assign take       = in_val_i & en_i;
    assign word_val_o = take & (cnt_q == 2'd3);
    assign word_o     = word_q;

    // Shifting in from the top leaves the first byte in the LSB after four takes.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (take) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {in_data_i, word_q[31:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/proc_mem_loader.sv
// Loads a byte-stream image into processor data memory, optionally verifies it, then releases core reset.
module proc_mem_loader
    import proc_loader_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int VERIFY   = 1,
    parameter int RST_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_words,
    input  logic             in_val,
    input  logic [7:0]       in_data,
    output logic             in_rdy,
    output logic             ext_dmemreq_val,
    output logic             ext_dmemreq_type,
    output logic [31:0]      ext_dmemreq_addr,
    output logic [31:0]      ext_dmemreq_wdata,
    input  logic [31:0]      ext_dmemresp_rdata,
    output logic             proc_rst,
    output logic             done,
    output logic             err,
    output logic [31:0]      err_sum
);

    localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      wsum_q, wsum_d;
    logic [31:0]      rsum_q, rsum_d;
    logic [31:0]      err_sum_q, err_sum_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic             pack_clear;
    logic             word_val;
    logic [31:0]      word;
    logic             start_ok;
    logic             last_word;
    logic [CNT_W-1:0] idx_inc;
    logic [31:0]      req_addr;

    loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (pack_clear),
        .en_i       (state_q == ST_PACK),
        .in_val_i   (in_val),
        .in_data_i  (in_data),
        .in_rdy_o   (in_rdy),
        .word_val_o (word_val),
        .word_o     (word)
    );

    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    assign idx_inc   = idx_q + CNT_W'(1);
    assign last_word = (idx_inc == num_q);
    // Address arithmetic is modulo 2^32 so a high base wraps to low memory.
    assign req_addr  = base_q + (32'(idx_q) << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            base_q    <= 32'd0;
            wsum_q    <= 32'd0;
            rsum_q    <= 32'd0;
            err_sum_q <= 32'd0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            base_q    <= base_d;
            wsum_q    <= wsum_d;
            rsum_q    <= rsum_d;
            err_sum_q <= err_sum_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        base_d     = base_q;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        err_sum_d  = err_sum_q;
        hold_d     = hold_q;
        pack_clear = 1'b0;
        if (start_ok) begin
            base_d     = base_addr & ~32'h3;
            num_d      = num_words;
            idx_d      = '0;
            wsum_d     = 32'd0;
            rsum_d     = 32'd0;
            hold_d     = '0;
            pack_clear = 1'b1;
            state_d    = (num_words == '0) ? ST_HOLD : ST_PACK;
        end else begin
            case (state_q)
                ST_PACK: begin
                    if (word_val) state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    wsum_d = wsum_q + word;
                    idx_d  = idx_inc;
                    if (!last_word) begin
                        state_d = ST_PACK;
                    end else if (VERIFY != 0) begin
                        idx_d   = '0;
                        state_d = ST_READ;
                    end else begin
                        hold_d  = '0;
                        state_d = ST_HOLD;
                    end
                end
                ST_READ: begin
                    rsum_d = rsum_q + ext_dmemresp_rdata;
                    if (last_word) state_d = ST_CHECK;
                    else           idx_d   = idx_inc;
                end
                ST_CHECK: begin
                    if (rsum_q == wsum_q) begin
                        hold_d  = '0;
                        state_d = ST_HOLD;
                    end else begin
                        err_sum_d = rsum_q;
                        state_d   = ST_ERROR;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = ST_DONE;
                    else                                 hold_d  = hold_q + HOLD_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ext_dmemreq_val   = 1'b0;
        ext_dmemreq_type  = MEMREQ_READ;
        ext_dmemreq_addr  = 32'd0;
        ext_dmemreq_wdata = 32'd0;
        proc_rst          = 1'b1;
        done              = 1'b0;
        err               = 1'b0;
        case (state_q)
            ST_WRITE: begin
                ext_dmemreq_val   = 1'b1;
                ext_dmemreq_type  = MEMREQ_WRITE;
                ext_dmemreq_addr  = req_addr;
                ext_dmemreq_wdata = word;
            end
            ST_READ: begin
                ext_dmemreq_val  = 1'b1;
                ext_dmemreq_type = MEMREQ_READ;
                ext_dmemreq_addr = req_addr;
            end
            ST_DONE: begin
                proc_rst = 1'b0;
                done     = 1'b1;
            end
            ST_ERROR: err = 1'b1;
            default: ;
        endcase
    end

    assign err_sum = err_sum_q;

endmodule
